// File: rtl/byp_hazard_ctrl.sv
// byp_hazard_ctrl -- decode-stage forwarding and load-use hazard controller.
//
// Tracks the write/load/destination status of the instructions in ID_EX and
// EX_DM and produces, for the instruction in ID, the bypass selects that its
// EX-stage source muxes will use. The selects are registered into ID_EX, so
// they travel alongside the consumer's ID_EX data flops.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   stall_ext            global freeze; every flop in this block holds
//   flush                taken branch/jump from EX; kills the ID instruction
//   re0_ID / re1_ID      ID instruction reads port 0 / port 1
//   p0_addr_ID/p1_addr_ID source registers of the ID instruction
//   we_ID, dst_addr_ID   ID instruction writes dst_addr_ID
//   ld_ID                ID instruction is a load (data valid after DM)
//   byp{0,1}_EX          registered: port takes the EX_DM result
//   byp{0,1}_DM          registered: port takes the DM_WB result
//   stall_IM_ID          combinational: hold PC and IM_ID
//   bubble_ID_EX         combinational: ID_EX control becomes a NOP
//
// DM_WB producers need no forwarding from here because the register file
// writes through in the same cycle, and a load in EX_DM is already
// forwardable from DM_WB by the time its consumer reaches EX. The DM_WB
// tracking stage and the EX_DM load flag therefore feed no output and are
// not kept.
module byp_hazard_ctrl #(
  parameter int RF_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_ext,
  input  logic             flush,
  input  logic             re0_ID,
  input  logic             re1_ID,
  input  logic [RF_AW-1:0] p0_addr_ID,
  input  logic [RF_AW-1:0] p1_addr_ID,
  input  logic             we_ID,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             ld_ID,
  output logic             byp0_EX,
  output logic             byp1_EX,
  output logic             byp0_DM,
  output logic             byp1_DM,
  output logic             stall_IM_ID,
  output logic             bubble_ID_EX
);

  // tracking state
  logic             we_id_ex_q, ld_id_ex_q;
  logic [RF_AW-1:0] dst_id_ex_q;
  logic             we_ex_dm_q;
  logic [RF_AW-1:0] dst_ex_dm_q;
  logic             byp0_ex_q, byp1_ex_q, byp0_dm_q, byp1_dm_q;

  // next-state
  logic             byp0_ex_d, byp1_ex_d, byp0_dm_d, byp1_dm_d;
  logic             m0_idex, m1_idex, m0_exdm, m1_exdm;
  logic             load_use, kill;

  // R0 is hard-wired zero, so a write to it is never a forwarding source.
  function automatic logic match(input logic [RF_AW-1:0] addr,
                                 input logic             we,
                                 input logic [RF_AW-1:0] dst);
    return we && (dst == addr) && (addr != '0);
  endfunction

  always_comb begin
    m0_idex   = match(p0_addr_ID, we_id_ex_q, dst_id_ex_q);
    m1_idex   = match(p1_addr_ID, we_id_ex_q, dst_id_ex_q);
    m0_exdm   = match(p0_addr_ID, we_ex_dm_q, dst_ex_dm_q);
    m1_exdm   = match(p1_addr_ID, we_ex_dm_q, dst_ex_dm_q);

    // EX and DM selects are independent; the EX mux gives EX priority.
    byp0_ex_d = re0_ID & m0_idex;
    byp1_ex_d = re1_ID & m1_idex;
    byp0_dm_d = re0_ID & m0_exdm;
    byp1_dm_d = re1_ID & m1_exdm;

    // Gated by rst so a load caught in ID_EX (e.g. reset during a freeze)
    // cannot raise a stall or bubble in the reset cycle.
    load_use  = ~rst & ld_id_ex_q & ((re0_ID & m0_idex) | (re1_ID & m1_idex));
    kill      = ~rst & flush;

    // A flushed consumer is dead, so it never needs to be held.
    stall_IM_ID  = stall_ext | (load_use & ~kill);
    bubble_ID_EX = ~stall_ext & (kill | load_use);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_id_ex_q  <= 1'b0;
      ld_id_ex_q  <= 1'b0;
      dst_id_ex_q <= '0;
      we_ex_dm_q  <= 1'b0;
      dst_ex_dm_q <= '0;
      byp0_ex_q   <= 1'b0;
      byp1_ex_q   <= 1'b0;
      byp0_dm_q   <= 1'b0;
      byp1_dm_q   <= 1'b0;
    end else if (!stall_ext) begin
      // EX_DM always advances; only ID_EX is replaced by a bubble.
      we_ex_dm_q  <= we_id_ex_q;
      dst_ex_dm_q <= dst_id_ex_q;
      if (bubble_ID_EX) begin
        we_id_ex_q  <= 1'b0;
        ld_id_ex_q  <= 1'b0;
        dst_id_ex_q <= '0;
        byp0_ex_q   <= 1'b0;
        byp1_ex_q   <= 1'b0;
        byp0_dm_q   <= 1'b0;
        byp1_dm_q   <= 1'b0;
      end else begin
        we_id_ex_q  <= we_ID;
        ld_id_ex_q  <= ld_ID;
        dst_id_ex_q <= dst_addr_ID;
        byp0_ex_q   <= byp0_ex_d;
        byp1_ex_q   <= byp1_ex_d;
        byp0_dm_q   <= byp0_dm_d;
        byp1_dm_q   <= byp1_dm_d;
      end
    end
  end

  assign byp0_EX = byp0_ex_q;
  assign byp1_EX = byp1_ex_q;
  assign byp0_DM = byp0_dm_q;
  assign byp1_DM = byp1_dm_q;

endmodule

// File: tb/tb_byp_hazard_ctrl.sv
module tb_byp_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, stall_ext, flush, re0_ID, re1_ID, we_ID, ld_ID;
  logic [3:0] p0_addr_ID, p1_addr_ID, dst_addr_ID;
  logic       byp0_EX, byp1_EX, byp0_DM, byp1_DM, stall_IM_ID, bubble_ID_EX;

  int n_cmp = 0;
  int n_bad = 0;

  byp_hazard_ctrl #(.RF_AW(4)) dut (
    .clk(clk), .rst(rst), .stall_ext(stall_ext), .flush(flush),
    .re0_ID(re0_ID), .re1_ID(re1_ID),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .we_ID(we_ID), .dst_addr_ID(dst_addr_ID), .ld_ID(ld_ID),
    .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
    .stall_IM_ID(stall_IM_ID), .bubble_ID_EX(bubble_ID_EX)
  );

  always #5 clk = ~clk;

  // one cycle of ID-stage stimulus with the expected combinational outputs in
  // that cycle and the expected registered selects after the edge
  typedef struct {
    logic       rst, sx, fl, re0, re1;
    logic [3:0] p0, p1;
    logic       we;
    logic [3:0] dst;
    logic       ld;
    logic       es, eb;
    logic [3:0] byp; // {byp0_EX, byp1_EX, byp0_DM, byp1_DM}
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp_q[$];

  function automatic vec_t mk(logic r, logic sx, logic fl, logic re0, logic re1,
                              logic [3:0] p0, logic [3:0] p1, logic we,
                              logic [3:0] dst, logic ld, logic es, logic eb,
                              logic [3:0] byp);
    vec_t v;
    v.rst = r; v.sx = sx; v.fl = fl; v.re0 = re0; v.re1 = re1;
    v.p0 = p0; v.p1 = p1; v.we = we; v.dst = dst; v.ld = ld;
    v.es = es; v.eb = eb; v.byp = byp;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    logic [3:0] e;
    @(negedge clk);
    rst = v.rst; stall_ext = v.sx; flush = v.fl;
    re0_ID = v.re0; re1_ID = v.re1; p0_addr_ID = v.p0; p1_addr_ID = v.p1;
    we_ID = v.we; dst_addr_ID = v.dst; ld_ID = v.ld;
    exp_q.push_back(v.byp);
    #1;
    check($sformatf("stall[%0d]", idx), {3'b0, stall_IM_ID}, {3'b0, v.es});
    check($sformatf("bubble[%0d]", idx), {3'b0, bubble_ID_EX}, {3'b0, v.eb});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("byp[%0d]", idx), {byp0_EX, byp1_EX, byp0_DM, byp1_DM}, e);
  endtask

  initial begin
    //             rst sx fl r0 r1 p0  p1  we dst ld es eb byp
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,  0,  0, 0,  0, 0, 0, 4'b0000)); // reset, flush ignored
    // ALU -> ALU back to back
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  2,  1, 3,  0, 0, 0, 4'b0000)); // ADD R3
    tbl.push_back(mk(0, 0, 0, 1, 1, 3,  4,  1, 6,  0, 0, 0, 4'b1000)); // SUB r3 on p0
    // producer, independent, consumer on port 1
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  2,  1, 7,  0, 0, 0, 4'b0000)); // R7
    tbl.push_back(mk(0, 0, 0, 1, 1, 9,  10, 1, 8,  0, 0, 0, 4'b0000)); // R8
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  7,  1, 9,  0, 0, 0, 4'b0001)); // reads R7 on p1
    // EX on one port, DM on the other; then both stages on both ports
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1,  1, 4,  0, 0, 0, 4'b0000)); // R4
    tbl.push_back(mk(0, 0, 0, 1, 1, 4,  9,  1, 4,  0, 0, 0, 4'b1001)); // R4 again
    tbl.push_back(mk(0, 0, 0, 1, 1, 4,  4,  0, 0,  0, 0, 0, 4'b1111));
    // load-use: one bubble, then DM forward
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  0,  1, 5,  1, 0, 0, 4'b0000)); // LW R5
    tbl.push_back(mk(0, 0, 0, 1, 1, 5,  2,  1, 6,  0, 1, 1, 4'b0000)); // hazard
    tbl.push_back(mk(0, 0, 0, 1, 1, 5,  2,  1, 6,  0, 0, 0, 4'b0010)); // replay
    // R0 never forwarded, never a load-use hazard
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  2,  1, 0,  0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0,  1, 0,  0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0,  1, 0,  1, 0, 0, 4'b0000)); // LW R0
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0,  0, 0,  0, 0, 0, 4'b0000));
    // read enables gate forwarding
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  0,  1, 11, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 11, 11, 1, 12, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 1, 11, 12, 0, 0,  0, 0, 0, 4'b0100));
    // flush beats load-use
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  0,  1, 2,  1, 0, 0, 4'b0000)); // LW R2
    tbl.push_back(mk(0, 0, 1, 1, 0, 2,  0,  1, 3,  0, 0, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2,  0,  1, 4,  0, 0, 0, 4'b0010));
    // R13 producer and EX-forwarding consumer before the freeze
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  0,  1, 13, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 1, 0, 13, 0,  1, 14, 0, 0, 0, 4'b1000));

    foreach (tbl[i]) apply(tbl[i], i);

    // stall_ext for 3 cycles: selects frozen, then resume from held state
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 0, 1, 1, 14, 13, 1, 15, 0, 1, 0, 4'b1000), 100 + k);
    apply(mk(0, 0, 0, 1, 1, 14, 13, 1, 15, 0, 0, 0, 4'b1001), 103);

    // reset mid-freeze with a load in ID_EX
    apply(mk(0, 0, 0, 1, 0, 1, 0, 1, 6, 1, 0, 0, 4'b0000), 110);           // LW R6
    apply(mk(1, 1, 0, 1, 0, 6, 0, 1, 7, 0, 1, 0, 4'b0000), 111);           // rst+stall
    apply(mk(0, 0, 0, 1, 0, 6, 0, 1, 7, 0, 0, 0, 4'b0000), 112);           // empty pipe

    // single-cycle reset with a load in ID_EX (flush ignored under reset)
    apply(mk(0, 0, 0, 1, 0, 1, 0, 1, 6, 1, 0, 0, 4'b0000), 120);
    apply(mk(1, 0, 1, 1, 0, 6, 0, 1, 7, 0, 0, 0, 4'b0000), 121);
    apply(mk(0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 4'b0000), 122);

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
